serial_alu_ctrl: RTL and testbench

//   Bit-serial sequencer that reuses one ALU_1bit slice to execute a WIDTH-bit operation, LSB first, one bit per clock.

---
 rtl/serial_alu_ctrl_pkg.sv | 16 +
 rtl/serial_alu_ctrl_slice.sv | 22 ++
 rtl/serial_alu_ctrl.sv | 78 +++++++
 tb/tb_serial_alu_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_ctrl_pkg.sv
// serial_alu_ctrl_pkg: ALU control codes and sequencer state encoding shared by the serial ALU files
package serial_alu_ctrl_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic is_arith(input logic [3:0] c);
    return c == ALU_ADD || c == ALU_SUB || c == ALU_SLT;
  endfunction
  function automatic logic is_logic(input logic [3:0] c);
    return c == ALU_AND || c == ALU_OR || c == ALU_NOR;
  endfunction
endpackage

// File: rtl/serial_alu_ctrl_slice.sv
// serial_alu_ctrl_slice: one-bit ALU slice (a/b optional invert; op 00 AND, 01 OR, 10 sum, 11 less); set is the raw sum bit
module serial_alu_ctrl_slice (
  input  logic       a,
  input  logic       b,
  input  logic       c_in,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic [1:0] op,
  input  logic       less,
  output logic       result,
  output logic       c_out,
  output logic       set
);
  logic aa, bb;
  always_comb begin
    aa = a ^ a_invert;
    bb = b ^ b_invert;
    set = aa ^ bb ^ c_in;
    c_out = (aa & bb) | (c_in & (aa ^ bb));
    result = op == 2'b00 ? aa & bb : op == 2'b01 ? aa | bb : op == 2'b10 ? set : less;
  end
endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU sequencer, one slice, LSB first; start/busy/done handshake, result + zero/c_out/overflow
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             c_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx, r_nx;
  logic [3:0] code;
  logic [CW-1:0] cnt;
  logic carry, accept, last, s_res, s_cout, s_set, ovf;
  serial_alu_ctrl_slice u_slice (
    .a(a_sh[0]), .b(b_sh[0]), .c_in(carry),
    .a_invert(code[3]), .b_invert(code[2]),
    .op(code == ALU_SLT ? 2'b10 : code[1:0]),
    .less(1'b0), .result(s_res), .c_out(s_cout), .set(s_set)
  );
  // Final-bit values are folded in combinationally so outputs load on the RUN->DONE edge.
  always_comb begin
    accept = start && state != RUN;
    last = cnt == CW'(WIDTH - 1);
    state_nx = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
    res_nx = {s_res, res_sh[WIDTH-1:1]};
    ovf = carry ^ s_cout;
    r_nx = code == ALU_SLT ? {{(WIDTH-1){1'b0}}, s_set ^ ovf} : (is_arith(code) || is_logic(code)) ? res_nx : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      a_sh <= '0;
      b_sh <= '0;
      res_sh <= '0;
      code <= '0;
      carry <= 1'b0;
      cnt <= '0;
      result <= '0;
      zero <= 1'b0;
      c_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh <= a;
        b_sh <= b;
        code <= alu_ctrl;
        carry <= alu_ctrl[2];
        cnt <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        res_sh <= res_nx;
        carry <= s_cout;
        cnt <= cnt + 1'b1;
        if (last) begin
          result <= r_nx;
          zero <= r_nx == '0;
          c_out <= is_arith(code) & s_cout;
          overflow <= is_arith(code) & ovf;
        end
      end
    end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed self-checking bench for serial_alu_ctrl at WIDTH=8
module tb_serial_alu_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] alu_ctrl = '0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, zero, c_out, overflow;
  logic [W-1:0] result;
  int checks = 0, errors = 0;
  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .c_out(c_out), .overflow(overflow)
  );
  always #5 clk = ~clk;
  // Accept on the posedge after the first negedge; lat counts negedges after that edge until done (expected W).
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    @(negedge clk);
    alu_ctrl = c; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y; alu_ctrl = 4'b1111;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    #2;
    checks++;
    if ({busy, done, zero, c_out, overflow, result} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b zero=%b c_out=%b ovf=%b result=%h, expected all 0", busy, done, zero, c_out, overflow, result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_add;
    int lat;
    run_op(4'b0010, 8'h7F, 8'h01, lat);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL add_latency: got %0d expected %0d", lat, W); end
    checks++;
    if ({result, zero, c_out, overflow} !== {8'h80, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_7f_01: got %h z%b c%b v%b expected 80 z0 c0 v1", result, zero, c_out, overflow);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
  endtask
  task automatic test_sub;
    int lat;
    run_op(4'b0110, 8'h05, 8'h05, lat);
    checks++;
    if ({result, zero, c_out, overflow} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_5_5: got %h z%b c%b v%b expected 00 z1 c1 v0", result, zero, c_out, overflow);
    end
    run_op(4'b0110, 8'h00, 8'h01, lat);
    checks++;
    if ({result, zero, c_out, overflow} !== {8'hFF, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_0_1: got %h z%b c%b v%b expected ff z0 c0 v0", result, zero, c_out, overflow);
    end
  endtask
  task automatic test_slt;
    int lat;
    run_op(4'b0111, 8'hFE, 8'h03, lat);
    checks++;
    if ({result, c_out, overflow} !== {8'h01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL slt_fe_03: got %h c%b v%b expected 01 c1 v0", result, c_out, overflow);
    end
    run_op(4'b0111, 8'h7F, 8'h80, lat);
    checks++;
    if ({result, zero, c_out, overflow} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL slt_7f_80: got %h z%b c%b v%b expected 00 z1 c0 v1", result, zero, c_out, overflow);
    end
    run_op(4'b0111, 8'h42, 8'h42, lat);
    checks++;
    if ({result, zero, c_out, overflow} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL slt_equal: got %h z%b c%b v%b expected 00 z1 c1 v0", result, zero, c_out, overflow);
    end
  endtask
  task automatic test_logic;
    int lat;
    logic [3:0] codes [3] = '{4'b0000, 4'b0001, 4'b1100};
    logic [7:0] exp [3] = '{8'h30, 8'hFC, 8'h03};
    for (int i = 0; i < 3; i++) begin
      run_op(codes[i], 8'hF0, 8'h3C, lat);
      checks++;
      if ({result, zero, c_out, overflow} !== {exp[i], 3'b000}) begin
        errors++; $display("FAIL logic_%b: got %h z%b c%b v%b expected %h z0 c0 v0", codes[i], result, zero, c_out, overflow, exp[i]);
      end
    end
  endtask
  task automatic test_unsupported;
    int lat;
    run_op(4'b0011, 8'hAA, 8'h55, lat);
    checks++;
    if (lat !== W || {result, zero, c_out, overflow} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL unsupported: got lat=%0d %h z%b c%b v%b expected lat=%0d 00 z1 c0 v0", lat, result, zero, c_out, overflow, W);
    end
  endtask
  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    alu_ctrl = 4'b0010; a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    alu_ctrl = 4'b0110; a = 8'hFF; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got busy=%b expected 1", busy); end
    lat = 4;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== W || result !== 8'h30) begin
      errors++; $display("FAIL ignore_start: got lat=%0d result=%h expected lat=%0d result=30", lat, result, W);
    end
  endtask
  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    alu_ctrl = 4'b0010; a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== W || result !== 8'h03) begin
      errors++; $display("FAIL b2b_first: got lat=%0d result=%h expected lat=%0d result=03", lat, result, W);
    end
    alu_ctrl = 4'b0110; a = 8'h09; b = 8'h04;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got done=%b busy=%b expected 0 1", done, busy); end
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== W || {result, c_out, overflow} !== {8'h05, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_second: got lat=%0d %h c%b v%b expected lat=%0d 05 c1 v0", lat, result, c_out, overflow, W);
    end
  endtask
  task automatic test_reset_mid_run;
    int lat;
    bit seen = 0;
    @(negedge clk);
    alu_ctrl = 4'b0010; a = 8'h7F; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, zero, c_out, overflow, result} !== 13'd0) begin
      errors++; $display("FAIL reset_mid_run: got busy=%b done=%b zero=%b c_out=%b ovf=%b result=%h expected all 0", busy, done, zero, c_out, overflow, result);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin @(negedge clk); seen |= done; end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_no_done: got done pulse expected none"); end
    run_op(4'b0000, 8'hFF, 8'h0F, lat);
    checks++;
    if (lat !== W || result !== 8'h0F) begin
      errors++; $display("FAIL reset_recover: got lat=%0d result=%h expected lat=%0d result=0f", lat, result, W);
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_slt;
    test_logic;
    test_unsupported;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
